// File: rtl/i2c_master_wr.sv
// I2C master write engine: START, 7-bit address + W, a streamed burst of data bytes, STOP.
// Open-drain outputs are low-enables; every ACK is checked and a NACK aborts to STOP.
module i2c_master_wr #(
    parameter int CLK_DIV = 250,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       slave_addr,
    input  logic [LEN_W-1:0] byte_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             scl_oe,
    output logic             busy,
    output logic             done,
    output logic             nack
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK,
        S_WAIT,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         qtr_q, qtr_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               nack_q, nack_d;
    logic               done_q, done_d;
    logic               tick;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));
    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign nack = nack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            remaining_q <= '0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            remaining_q <= remaining_d;
            nack_q      <= nack_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        qtr_d       = tick ? qtr_q + 2'd1 : qtr_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
        nack_d      = nack_q;
        done_d      = 1'b0;
        tx_ready    = 1'b0;
        scl_oe      = 1'b0;
        sda_oe      = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                qtr_d = '0;
                if (start) begin
                    state_d     = S_START;
                    bit_d       = '0;
                    shreg_d     = {slave_addr, 1'b0};
                    remaining_d = byte_len;
                    nack_d      = 1'b0;
                end
            end
            S_START: begin
                sda_oe = qtr_q[1];
                if (tick && qtr_q == 2'd3) begin
                    state_d = S_ADDR;
                    bit_d   = '0;
                end
            end
            S_ADDR, S_DATA: begin
                scl_oe = ~qtr_q[1];
                sda_oe = ~shreg_q[7];
                if (tick && qtr_q == 2'd3) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_ACK;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end
            end
            S_ACK: begin
                scl_oe = ~qtr_q[1];
                // Slave response is sampled on the edge entering q3, mid SCL-high.
                if (tick && qtr_q == 2'd2 && sda_i) begin
                    nack_d = 1'b1;
                end
                if (tick && qtr_q == 2'd3) begin
                    if (nack_q || remaining_q == '0) begin
                        state_d = S_STOP;
                    end else if (tx_valid) begin
                        tx_ready    = 1'b1;
                        shreg_d     = tx_data;
                        remaining_d = remaining_q - LEN_W'(1);
                        bit_d       = '0;
                        state_d     = S_DATA;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                scl_oe = 1'b1;
                sda_oe = 1'b1;
                div_d  = '0;
                qtr_d  = '0;
                if (tx_valid) begin
                    tx_ready    = 1'b1;
                    shreg_d     = tx_data;
                    remaining_d = remaining_q - LEN_W'(1);
                    bit_d       = '0;
                    state_d     = S_DATA;
                end
            end
            S_STOP: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = ~qtr_q[1];
                if (tick && qtr_q == 2'd3) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_wr.sv
// Directed and randomized checks of i2c_master_wr against a bit-stream/latency model with an
// ACK-responding slave and a valid/ready byte source.
module tb_i2c_master_wr;

    localparam int CLK_DIV = 4;
    localparam int LEN_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [6:0]       slave_addr;
    logic [LEN_W-1:0] byte_len;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             sda_i;
    logic             sda_oe;
    logic             scl_oe;
    logic             busy;
    logic             done;
    logic             nack;

    i2c_master_wr #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .slave_addr (slave_addr),
        .byte_len   (byte_len),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .sda_i      (sda_i),
        .sda_oe     (sda_oe),
        .scl_oe     (scl_oe),
        .busy       (busy),
        .done       (done),
        .nack       (nack)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int cyc, done_cyc, done_cnt, ready_cnt, gap_left;
    int rises, hi_edges, run_len, max_run, ack_byte, nack_byte;
    logic ack_phase, prev_scl, prev_sda;
    logic [7:0] src_q[$];
    int         gap_q[$];
    logic [7:0] exp_data[$];
    logic       obs_bits[$];
    logic       exp_bits[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic presentNext();
        int g;
        if (src_q.size() == 0) begin
            tx_valid = 1'b0;
        end else begin
            g = gap_q.pop_front();
            if (g == 0) begin
                tx_valid = 1'b1;
                tx_data  = src_q[0];
            end else begin
                tx_valid = 1'b0;
                gap_left = g;
            end
        end
    endtask

    // One clock: source handshake, done tracking, bus monitor and slave ACK response.
    task automatic stepCycle();
        logic       rdy;
        logic [7:0] tmp;
        @(negedge clk);
        rdy = tx_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (rdy === 1'b1) begin
            ready_cnt++;
            if (src_q.size() > 0) tmp = src_q.pop_front();
            presentNext();
        end else if (gap_left > 0) begin
            gap_left--;
            if (gap_left == 0) begin
                tx_valid = 1'b1;
                tx_data  = src_q[0];
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = cyc;
        end
        if (prev_scl === 1'b1 && scl_oe === 1'b0) begin
            obs_bits.push_back(!sda_oe);
            rises++;
        end
        if (prev_scl === 1'b0 && scl_oe === 1'b1) begin
            ack_phase = (rises % 9 == 8);
            ack_byte  = rises / 9;
        end
        if (prev_scl === 1'b0 && scl_oe === 1'b0 && prev_sda !== sda_oe) hi_edges++;
        sda_i = (ack_phase && ack_byte != nack_byte) ? 1'b0 : 1'b1;
        if (scl_oe === 1'b1 && sda_oe === 1'b1) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        prev_scl = scl_oe;
        prev_sda = sda_oe;
    endtask

    task automatic loadSource(input logic [7:0] b, input int gap);
        src_q.push_back(b);
        gap_q.push_back(gap);
        exp_data.push_back(b);
    endtask

    task automatic clearSource();
        src_q    = {};
        gap_q    = {};
        exp_data = {};
        gap_left = 0;
    endtask

    task automatic applyStimulus(input logic [6:0] addr, input int len, input int nk);
        obs_bits   = {};
        rises      = 0;
        hi_edges   = 0;
        run_len    = 0;
        max_run    = 0;
        ack_phase  = 1'b0;
        done_cyc   = 0;
        done_cnt   = 0;
        ready_cnt  = 0;
        nack_byte  = nk;
        slave_addr = addr;
        byte_len   = LEN_W'(len);
        start      = 1'b1;
        presentNext();
        cyc = 0;
        stepCycle();
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("nack_cleared", nack, 0);
    endtask

    task automatic waitDone(input int limit);
        int k = 0;
        while (done_cyc == 0 && k < limit) begin
            stepCycle();
            k++;
        end
        checkOutput("done_seen", (done_cyc != 0), 1);
        checkOutput("busy_at_done", busy, 0);
    endtask

    // Reference stream: each byte MSB first then a released ACK slot, then the STOP SCL rise with SDA low.
    task automatic checkStream(input string tag, input logic [6:0] addr, input int m);
        logic [7:0] b;
        int bad = 0;
        exp_bits = {};
        for (int j = 0; j <= m; j++) begin
            b = (j == 0) ? {addr, 1'b0} : exp_data[j-1];
            for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
            exp_bits.push_back(1'b1);
        end
        exp_bits.push_back(1'b0);
        checkOutput({tag, "_bitcount"}, obs_bits.size(), exp_bits.size());
        for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++)
            if (obs_bits[i] !== exp_bits[i]) bad++;
        checkOutput({tag, "_bits"}, bad, 0);
        checkOutput({tag, "_start_stop_edges"}, hi_edges, 2);
    endtask

    function automatic int expDone(input int m);
        return (8 + 36 * (m + 1)) * CLK_DIV + 1;
    endfunction

    initial begin
        logic [6:0] a;
        int len, nk, m;

        rst = 1'b1; start = 1'b0; slave_addr = '0; byte_len = '0;
        tx_data = '0; tx_valid = 1'b0; sda_i = 1'b1;
        prev_scl = 1'b0; prev_sda = 1'b0; ack_phase = 1'b0; nack_byte = -1;
        cyc = 0; done_cyc = 0; done_cnt = 0; ready_cnt = 0; gap_left = 0;
        rises = 0; hi_edges = 0; run_len = 0; max_run = 0; ack_byte = 0;
        repeat (3) stepCycle();
        checkOutput("rst_tx_ready", tx_ready, 0);
        checkOutput("rst_sda_oe", sda_oe, 0);
        checkOutput("rst_scl_oe", scl_oe, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_nack", nack, 0);
        rst = 1'b0;
        repeat (2) stepCycle();

        $display("[TB] single byte write");
        clearSource();
        loadSource(8'hA5, 0);
        applyStimulus(7'h50, 1, -1);
        waitDone(3000);
        checkOutput("t1_done_cycle", done_cyc, expDone(1));
        checkOutput("t1_ready_count", ready_cnt, 1);
        checkOutput("t1_nack", nack, 0);
        checkStream("t1", 7'h50, 1);
        repeat (3) stepCycle();
        checkOutput("t1_done_pulses", done_cnt, 1);

        $display("[TB] address NACK");
        clearSource();
        loadSource(8'hA5, 0);
        applyStimulus(7'h50, 1, 0);
        waitDone(3000);
        checkOutput("t2_done_cycle", done_cyc, expDone(0));
        checkOutput("t2_ready_count", ready_cnt, 0);
        checkOutput("t2_nack", nack, 1);
        checkStream("t2", 7'h50, 0);
        repeat (3) stepCycle();

        $display("[TB] address probe");
        clearSource();
        applyStimulus(7'h3C, 0, -1);
        waitDone(3000);
        checkOutput("t3_done_cycle", done_cyc, expDone(0));
        checkOutput("t3_ready_count", ready_cnt, 0);
        checkOutput("t3_nack", nack, 0);
        checkStream("t3", 7'h3C, 0);
        repeat (3) stepCycle();

        $display("[TB] stalled burst");
        clearSource();
        loadSource(8'h11, 0);
        loadSource(8'h22, 244);
        loadSource(8'h33, 0);
        applyStimulus(7'h21, 3, -1);
        waitDone(5000);
        checkOutput("t4_done_late", (done_cyc >= expDone(3) + 100 && done_cyc <= expDone(3) + 105), 1);
        checkOutput("t4_ready_count", ready_cnt, 3);
        checkOutput("t4_wait_held_low", (max_run >= 100), 1);
        checkStream("t4", 7'h21, 3);
        repeat (3) stepCycle();

        $display("[TB] reset mid data");
        clearSource();
        loadSource(8'($urandom), 0);
        loadSource(8'($urandom), 0);
        applyStimulus(7'h12, 2, -1);
        while (cyc < 200) stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("t5_rst_scl", scl_oe, 0);
        checkOutput("t5_rst_sda", sda_oe, 0);
        checkOutput("t5_rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) stepCycle();
        clearSource();
        loadSource(8'($urandom), 0);
        loadSource(8'($urandom), 0);
        applyStimulus(7'h12, 2, -1);
        waitDone(3000);
        checkOutput("t5_done_cycle", done_cyc, expDone(2));
        checkStream("t5", 7'h12, 2);
        repeat (3) stepCycle();

        $display("[TB] start while busy");
        clearSource();
        loadSource(8'($urandom), 0);
        applyStimulus(7'h2A, 1, -1);
        while (cyc < 50) stepCycle();
        start = 1'b1;
        slave_addr = 7'h55;
        stepCycle();
        start = 1'b0;
        waitDone(3000);
        repeat (3) stepCycle();
        checkOutput("t6_done_cycle", done_cyc, expDone(1));
        checkOutput("t6_done_pulses", done_cnt, 1);
        checkStream("t6", 7'h2A, 1);
        repeat (3) stepCycle();

        $display("[TB] randomized transfers");
        for (int t = 0; t < 5; t++) begin
            a   = 7'($urandom);
            len = $urandom_range(0, 3);
            nk  = $urandom_range(0, len + 1);
            if (nk == len + 1) nk = -1;
            m = (nk < 0) ? len : nk;
            clearSource();
            for (int j = 0; j < len; j++) loadSource(8'($urandom), 0);
            applyStimulus(a, len, nk);
            waitDone(3000);
            checkOutput("rnd_done_cycle", done_cyc, expDone(m));
            checkOutput("rnd_ready_count", ready_cnt, m);
            checkOutput("rnd_nack", nack, (nk >= 0) ? 1 : 0);
            checkStream("rnd", a, m);
            repeat (3) stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
